// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, opcode classification and ALU latency for the issue stage
package alu_pkg;

    localparam int ALU_LAT = 2;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b1000,
        OP_OR  = 4'b1001,
        OP_XOR = 4'b1010,
        OP_NOT = 4'b1011,
        OP_SHR = 4'b1100,
        OP_SHL = 4'b1101,
        OP_ROR = 4'b1110,
        OP_ROL = 4'b1111
    } alu_op_e;

    function automatic logic is_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || op[3];
    endfunction

    // NOT and the shift/rotate group read only operand A
    function automatic logic is_unary(input logic [3:0] op);
        return op[3] && (op[2] || (op[1] && op[0]));
    endfunction

endpackage

// File: rtl/alu_issue_ctl_if.sv
// rtl/alu_issue_ctl_if.sv - instruction valid/ready handshake into the issue stage
interface alu_issue_ctl_if #(
    parameter int W  = 8,
    parameter int AW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic          in_ldi;
    logic [3:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic [W-1:0]  in_imm;

    modport master (
        output in_valid, in_ldi, in_op, in_rd, in_rs1, in_rs2, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_ldi, in_op, in_rd, in_rs1, in_rs2, in_imm,
        output in_ready
    );
endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - NREG x W register file, two operand reads, one debug read, one write
module alu_regfile #(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    output logic [W-1:0]  o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [W-1:0]  o_rdata_b,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [W-1:0]  o_dbg_data
);

    logic [W-1:0] r_mem [NREG];

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue_ctl.sv
// rtl/alu_issue_ctl.sv - operand supply, hazard stall/forwarding and write-back for the 2-stage ALU
module alu_issue_ctl
    import alu_pkg::*;
#(
    parameter int W    = 8,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic            ck,
    input  logic            rst_n,
    alu_issue_ctl_if.slave  in_if,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [3:0]      alu_ctr,
    input  logic [W-1:0]    alu_o,
    input  logic [AW-1:0]   dbg_addr,
    output logic [W-1:0]    dbg_data,
    output logic            busy,
    output logic            err
);

    logic          r_s1_v;
    logic          r_s1_ldi;
    logic [AW-1:0] r_s1_rd;
    logic [W-1:0]  r_s1_imm;
    logic          r_s2_v;
    logic          r_s2_ldi;
    logic [AW-1:0] r_s2_rd;
    logic [W-1:0]  r_s2_imm;
    logic          r_err;

    logic          w_legal;
    logic          w_unary;
    logic          w_s1_blocks;
    logic          w_haz_a;
    logic          w_haz_b;
    logic          w_hazard;
    logic          w_accept;
    logic          w_enter;
    logic          w_illegal;
    logic [W-1:0]  w_s2_result;
    logic [W-1:0]  w_rdata_a;
    logic [W-1:0]  w_rdata_b;
    logic [W-1:0]  w_opa;
    logic [W-1:0]  w_opb;

    assign w_legal = is_legal(in_if.in_op);
    assign w_unary = is_unary(in_if.in_op);

    // An LDI in s1 already holds its value, so only an ALU op in s1 forces a stall
    assign w_s1_blocks = r_s1_v && !r_s1_ldi;
    assign w_haz_a     = !in_if.in_ldi && w_legal && w_s1_blocks
                         && (in_if.in_rs1 == r_s1_rd);
    assign w_haz_b     = !in_if.in_ldi && w_legal && !w_unary && w_s1_blocks
                         && (in_if.in_rs2 == r_s1_rd);
    assign w_hazard    = w_haz_a || w_haz_b;

    assign in_if.in_ready = !w_hazard;
    assign w_accept       = in_if.in_valid && !w_hazard;
    assign w_enter        = w_accept && (in_if.in_ldi || w_legal);
    assign w_illegal      = w_accept && !in_if.in_ldi && !w_legal;

    assign w_s2_result = r_s2_ldi ? r_s2_imm : alu_o;

    alu_regfile #(
        .W    (W),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .ck         (ck),
        .rst_n      (rst_n),
        .i_we       (r_s2_v),
        .i_waddr    (r_s2_rd),
        .i_wdata    (w_s2_result),
        .i_raddr_a  (in_if.in_rs1),
        .o_rdata_a  (w_rdata_a),
        .i_raddr_b  (in_if.in_rs2),
        .o_rdata_b  (w_rdata_b),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    // Youngest producer wins: s1 (LDI only) before s2 before the regfile
    always_comb begin
        w_opa = w_rdata_a;
        if (r_s1_v && r_s1_ldi && (in_if.in_rs1 == r_s1_rd)) begin
            w_opa = r_s1_imm;
        end else if (r_s2_v && (in_if.in_rs1 == r_s2_rd)) begin
            w_opa = w_s2_result;
        end
    end

    always_comb begin
        w_opb = w_rdata_b;
        if (r_s1_v && r_s1_ldi && (in_if.in_rs2 == r_s1_rd)) begin
            w_opb = r_s1_imm;
        end else if (r_s2_v && (in_if.in_rs2 == r_s2_rd)) begin
            w_opb = w_s2_result;
        end
    end

    assign alu_a   = w_opa;
    assign alu_b   = w_opb;
    assign alu_ctr = in_if.in_op;

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_ldi <= 1'b0;
            r_s1_rd  <= '0;
            r_s1_imm <= '0;
        end else begin
            r_s1_v   <= w_enter;
            r_s1_ldi <= in_if.in_ldi;
            r_s1_rd  <= in_if.in_rd;
            r_s1_imm <= in_if.in_imm;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_v   <= 1'b0;
            r_s2_ldi <= 1'b0;
            r_s2_rd  <= '0;
            r_s2_imm <= '0;
        end else begin
            r_s2_v   <= r_s1_v;
            r_s2_ldi <= r_s1_ldi;
            r_s2_rd  <= r_s1_rd;
            r_s2_imm <= r_s1_imm;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_illegal) begin
            r_err <= 1'b1;
        end
    end

    assign err  = r_err;
    assign busy = r_s1_v || r_s2_v;

endmodule
